// File: rtl/rpn_stack_controller.sv
// Operand stack and ALU sequencer for the 8-bit RPN calculator.
// PUSH adds an operand to the stack. EXEC pops the two top entries and runs one
// start/done transaction on the shared ALU. A successful result is pushed back.
// A watchdog aborts the transaction if the ALU never answers.
module rpn_stack_controller #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     CLEAR,
  input  logic                     PUSH,
  input  logic [WIDTH-1:0]         DATA_IN,
  input  logic                     EXEC,
  input  logic [2:0]               OPCODE,
  output logic [WIDTH-1:0]         ALU_A,
  output logic [WIDTH-1:0]         ALU_B,
  output logic [2:0]               ALU_OP,
  output logic                     ALU_START,
  input  logic                     ALU_DONE,
  input  logic [WIDTH-1:0]         ALU_RESULT,
  input  logic                     ALU_ERR,
  output logic [WIDTH-1:0]         TOP,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY,
  output logic [2:0]               ERROR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [7:0]    WD_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] E_NONE  = 3'b000;
  localparam logic [2:0] E_UNDER = 3'b001;
  localparam logic [2:0] E_OVER  = 3'b010;
  localparam logic [2:0] E_ALU   = 3'b011;
  localparam logic [2:0] E_TMO   = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  top_q, top_d;
  logic [2:0]        err_q, err_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [7:0]        wdog_q, wdog_d;

  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic [AW-1:0]     nos_idx, tos_idx;

  assign nos_idx = AW'(cnt_q - CW'(2));
  assign tos_idx = AW'(cnt_q - CW'(1));

  // Next-state logic: command decode in IDLE, the ALU handshake, and the watchdog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    start_d = 1'b0;
    wdog_d  = wdog_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q[AW-1:0];
    wr_data = DATA_IN;
    if (CLEAR) begin
      // Abandon any transaction. A result that arrives later lands in IDLE and is ignored.
      state_d = S_IDLE;
      cnt_d   = '0;
      top_d   = '0;
      err_d   = E_NONE;
      wdog_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EXEC) begin
            // EXEC has priority over a simultaneous PUSH, so that PUSH is dropped.
            if (cnt_q >= CW'(2)) begin
              a_d     = stack_q[nos_idx];
              b_d     = stack_q[tos_idx];
              op_d    = OPCODE;
              err_d   = E_NONE;
              start_d = 1'b1;
              state_d = S_ISSUE;
            end else begin
              err_d = E_UNDER;
            end
          end else if (PUSH) begin
            if (cnt_q != FULL) begin
              wr_en = 1'b1;
              cnt_d = cnt_q + CW'(1);
              top_d = DATA_IN;
              err_d = E_NONE;
            end else begin
              err_d = E_OVER;
            end
          end
        end
        S_ISSUE: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ALU_DONE) begin
            state_d = S_IDLE;
            if (ALU_ERR) begin
              err_d = E_ALU;
            end else begin
              // The result replaces NOS, and the old TOS is dropped.
              wr_en   = 1'b1;
              wr_idx  = nos_idx;
              wr_data = ALU_RESULT;
              cnt_d   = cnt_q - CW'(1);
              top_d   = ALU_RESULT;
            end
          end else if (wdog_q == WD_LAST) begin
            err_d   = E_TMO;
            state_d = S_IDLE;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers. All outputs come straight from flops.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      top_q   <= '0;
      err_q   <= E_NONE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      wdog_q  <= wdog_d;
    end
  end

  // Stack storage. It has no reset because COUNT alone decides which entries are valid.
  always_ff @(posedge CLOCK) begin
    if (wr_en) stack_q[wr_idx] <= wr_data;
  end

  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_OP    = op_q;
  assign ALU_START = start_q;
  assign TOP       = top_q;
  assign COUNT     = cnt_q;
  assign BUSY      = busy_q;
  assign ERROR     = err_q;

endmodule

// File: doc/rpn_stack_controller.md
Name: rpn_stack_controller

Overview:
- Operand-stack controller and ALU sequencer for the 8-bit RPN calculator.
- Accepts PUSH (operand entry) and EXEC (operator entry) commands and keeps a DEPTH-entry operand stack.
- On EXEC it pops the two top operands, issues one start/done transaction to the shared ALU, and pushes the result back.
- An internal 8-bit watchdog counter aborts the transaction if the ALU never answers.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, stack entries; power of two, 2..8
TIMEOUT, 255, max WAIT cycles before abort; 1..255

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-high reset
CLEAR  in  1  synchronous clear of stack, error and any transaction
PUSH  in  1  push DATA_IN (one-cycle strobe)
DATA_IN  in  WIDTH  operand to push
EXEC  in  1  execute OPCODE on the two top entries (one-cycle strobe)
OPCODE  in  3  operation code, passed through to the ALU
ALU_A  out  WIDTH  first operand = entry below top (NOS)
ALU_B  out  WIDTH  second operand = top of stack
ALU_OP  out  3  latched OPCODE
ALU_START  out  1  one-cycle start pulse
ALU_DONE  in  1  ALU result valid
ALU_RESULT  in  WIDTH  ALU result
ALU_ERR  in  1  ALU error flag, qualified by ALU_DONE
TOP  out  WIDTH  top-of-stack value; 0 when empty
COUNT  out  clog2(DEPTH)+1  number of valid entries
BUSY  out  1  high while not in IDLE
ERROR  out  3  000 none, 001 underflow, 010 overflow, 011 ALU error, 100 timeout

Behaviour:
- Reset (async, RESET=1): state IDLE; COUNT=0; TOP=0; ERROR=000; BUSY=0; ALU_START=0; ALU_A=ALU_B=0; ALU_OP=000; watchdog=0. Stack contents do not need clearing.
- States: IDLE -> ISSUE -> WAIT -> IDLE. All outputs are registered.
- IDLE, EXEC=1, COUNT>=2:
  - Latch ALU_A=stack[COUNT-2], ALU_B=stack[COUNT-1], ALU_OP=OPCODE.
  - ERROR=000; go to ISSUE.
- IDLE, EXEC=1, COUNT<2: stay in IDLE, stack unchanged, ERROR=001.
- IDLE, PUSH=1, EXEC=0:
  - COUNT<DEPTH: write DATA_IN at index COUNT, COUNT+1, TOP=DATA_IN, ERROR=000.
  - COUNT==DEPTH: stack unchanged, ERROR=010.
- PUSH and EXEC together in IDLE: EXEC wins and PUSH is dropped silently.
- ISSUE (exactly 1 cycle): ALU_START=1, BUSY=1; clear watchdog; go to WAIT. ALU_DONE is ignored in ISSUE.
- WAIT:
  - ALU_START=0; ALU_A, ALU_B and ALU_OP are held stable.
  - Watchdog increments on each WAIT cycle with ALU_DONE=0.
- WAIT, ALU_DONE=1, ALU_ERR=0:
  - Replace the two top entries with ALU_RESULT: COUNT-1, TOP=ALU_RESULT.
  - Go to IDLE.
- WAIT, ALU_DONE=1, ALU_ERR=1: stack untouched (operands kept), ERROR=011, go to IDLE.
- WAIT timeout:
  - Condition: watchdog==TIMEOUT-1 and ALU_DONE=0, so ALU_DONE is accepted on WAIT cycles 1..TIMEOUT.
  - Action: stack untouched, ERROR=100, go to IDLE.
  - A late ALU_DONE arriving in IDLE is ignored.
- PUSH and EXEC while BUSY=1: ignored, with no error.
- ERROR is sticky until the next accepted PUSH/EXEC, CLEAR, or RESET.
- CLEAR=1 (any state, priority over all commands): COUNT=0, TOP=0, ERROR=000, ALU_START=0, state IDLE. An in-flight ALU result is discarded.
- Latency:
  - EXEC sampled on edge n -> ALU_START high during cycle n+1.
  - Earliest DONE sampled on edge n+2 -> TOP/COUNT updated after edge n+2.
  - BUSY high cycles n+1 .. DONE edge.
- Watchdog and ALU_START are driven only by the state machine; the watchdog wraps never (saturates by exiting WAIT).

Test Plan:
- Basic push/add: reset, PUSH 0x05, PUSH 0x03, EXEC op=000, ALU model returns 0x08 with DONE 1 cycle after START -> ALU_A=0x05, ALU_B=0x03, START one cycle, COUNT=1, TOP=0x08, ERROR=000.
- Overflow and underflow: PUSH 5 values with DEPTH=4 -> COUNT=4, ERROR=010, TOP=4th value. After CLEAR, PUSH 0x11 then EXEC -> ERROR=001, COUNT=1, BUSY never asserted.
- ALU error: ALU model asserts DONE with ERR=1 -> COUNT and TOP unchanged, ERROR=011. A following valid PUSH clears ERROR to 000.
- Timeout: ALU never answers with TIMEOUT=4 -> BUSY high 5 cycles (ISSUE + 4 WAIT), then ERROR=100, stack unchanged. DONE injected 2 cycles later is ignored.
- Busy and priority: PUSH and EXEC asserted together in IDLE -> EXEC executed, DATA_IN not stored. PUSH during WAIT -> ignored, COUNT unchanged after completion.
- Reset and clear mid-operation: RESET asserted asynchronously during WAIT -> all outputs 0 immediately, START never re-issued. CLEAR during WAIT followed by DONE -> COUNT=0, TOP=0.
